// File: rtl/btn_ctrl_pkg.sv
// Shared constants and helpers for the push-button front end (debounce channels + arbiter).
// Optional round-robin arbitration is selected in the top level by BUTTON_CTRL_ROUND_ROBIN_EN.
package btn_ctrl_pkg;

   localparam int DEF_N_BUTTONS       = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 8;

   // Wraps an index that has overshot n by at most n back into 0..n-1.
   function automatic int wrap_idx(input int i, input int n);
      return (i >= n) ? i - n : i;
   endfunction

endpackage

// File: rtl/button_input_controller_debounce_channel.sv
// One button channel: two-flop synchronizer followed by a consecutive-sample debounce counter.
// rise pulses combinationally in the cycle whose edge flips the stable level from 0 to 1.
module debounce_channel
   import btn_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      rise    = 1'b0;
      // Any sample that agrees with the stable level restarts the count.
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TERM) begin
         level_d = sync2_q;
         cnt_d   = '0;
         rise    = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/button_input_controller.sv
// Push-button front end: per-button debounce, pending-press latch, arbiter and valid/ready event register.
// Define BUTTON_CTRL_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
//
// Handshake: out_valid/out_id form a registered source. An event transfers on a rising edge where
// out_valid && out_ready; while out_valid && !out_ready, out_id holds and new presses stay pending.
module button_input_controller
   import btn_ctrl_pkg::*;
#(
   parameter int N_BUTTONS       = DEF_N_BUTTONS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int ID_W            = $clog2(N_BUTTONS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] button,
   output logic                 out_valid,
   output logic [ID_W-1:0]      out_id,
   input  logic                 out_ready,
   output logic [N_BUTTONS-1:0] level,
   output logic                 dropped
);

   logic [N_BUTTONS-1:0] level_w;
   logic [N_BUTTONS-1:0] rise_w;

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk  (clk),
         .reset(reset),
         .raw  (button[g]),
         .level(level_w[g]),
         .rise (rise_w[g])
      );
   end

   logic [N_BUTTONS-1:0] pending_q, pending_d;
   logic                 out_valid_q, out_valid_d;
   logic [ID_W-1:0]      out_id_q, out_id_d;
   logic                 dropped_q, dropped_d;
   logic                 grant_any;
   logic [ID_W-1:0]      grant_idx;
   logic                 load;
   logic [N_BUTTONS-1:0] grant_vec;

`ifdef BUTTON_CTRL_ROUND_ROBIN_EN
   logic [ID_W-1:0] ptr_q, ptr_d;

   // First pending index at or after the pointer, wrapping.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_BUTTONS; k++) begin
         if (!grant_any && pending_q[wrap_idx(int'(ptr_q) + k, N_BUTTONS)]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(wrap_idx(int'(ptr_q) + k, N_BUTTONS));
         end
      end
   end
`else
   // Scan high to low so the lowest pending index is the last writer.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = N_BUTTONS - 1; k >= 0; k--) begin
         if (pending_q[k]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(k);
         end
      end
   end
`endif

   always_comb begin
      load        = !out_valid_q || out_ready;
      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      dropped_d   = dropped_q;
      grant_vec   = '0;
`ifdef BUTTON_CTRL_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      if (load) begin
         out_valid_d = grant_any;
         if (grant_any) begin
            out_id_d             = grant_idx;
            grant_vec[grant_idx] = 1'b1;
`ifdef BUTTON_CTRL_ROUND_ROBIN_EN
            ptr_d                = ID_W'(wrap_idx(int'(grant_idx) + 1, N_BUTTONS));
`endif
         end
      end
      // A rise on the granted channel re-arms it rather than merging into the grant.
      pending_d = (pending_q & ~grant_vec) | rise_w;
      if (|(rise_w & pending_q & ~grant_vec)) begin
         dropped_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         dropped_q   <= 1'b0;
`ifdef BUTTON_CTRL_ROUND_ROBIN_EN
         ptr_q       <= '0;
`endif
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         dropped_q   <= dropped_d;
`ifdef BUTTON_CTRL_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign level     = level_w;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_button_input_controller.sv
// Self-checking bench for button_input_controller (4 buttons, debounce 8); event ids go through a queue.
module tb_button_input_controller;

   localparam int NB = 4;
   localparam int IW = 2;

`ifdef BUTTON_CTRL_ROUND_ROBIN_EN
   localparam logic [IW-1:0] RR_SECOND = 2'd1;
   localparam logic [IW-1:0] RR_THIRD  = 2'd0;
`else
   localparam logic [IW-1:0] RR_SECOND = 2'd0;
   localparam logic [IW-1:0] RR_THIRD  = 2'd1;
`endif

   logic          clk;
   logic          reset;
   logic [NB-1:0] button;
   logic          out_valid;
   logic [IW-1:0] out_id;
   logic          out_ready;
   logic [NB-1:0] level;
   logic          dropped;

   logic [IW-1:0] exp_q[$];
   int            n_cmp;
   int            n_err;
   int            extra_cnt;

   button_input_controller #(
      .N_BUTTONS      (NB),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .button   (button),
      .out_valid(out_valid),
      .out_id   (out_id),
      .out_ready(out_ready),
      .level    (level),
      .dropped  (dropped)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted event must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() > 0) check_eq("evt_id", 32'(out_id), 32'(exp_q.pop_front()));
         else extra_cnt++;
      end
   end

   task automatic release_and_drain(input string tag);
      button = '0;
      tick(14);
      check_eq(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; extra_cnt = 0;
      reset = 1'b1; button = '0; out_ready = 1'b1;
      tick(3);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_id", 32'(out_id), 32'd0);
      check_eq("rst_dropped", 32'(dropped), 32'd0);
      reset = 1'b0;
      tick(2);

      // Clean press on button 2
      button[2] = 1'b1; exp_q.push_back(2'd2);
      tick(9);  check_eq("t1_level_e8", 32'(level), 32'h0);
      tick(1);  check_eq("t1_level_e9", 32'(level), 32'h4);
                check_eq("t1_valid_e9", 32'(out_valid), 32'd0);
      tick(1);  check_eq("t1_valid_e10", 32'(out_valid), 32'd1);
                check_eq("t1_id_e10", 32'(out_id), 32'd2);
      tick(1);  check_eq("t1_valid_e11", 32'(out_valid), 32'd0);
      release_and_drain("t1_drain");

      // Bounce on button 0, then steady
      for (int i = 0; i < 10; i++) begin
         button[0] = (i % 2 == 0);
         tick(1);
      end
      check_eq("t2_level_bounce", 32'(level), 32'h0);
      button[0] = 1'b1; exp_q.push_back(2'd0);
      tick(10); check_eq("t2_valid_e9", 32'(out_valid), 32'd0);
      tick(1);  check_eq("t2_valid_e10", 32'(out_valid), 32'd1);
                check_eq("t2_id_e10", 32'(out_id), 32'd0);
      release_and_drain("t2_drain");

      // Backpressure with buttons 1 and 3 together
      out_ready = 1'b0;
      button[1] = 1'b1; button[3] = 1'b1;
      exp_q.push_back(2'd1); exp_q.push_back(2'd3);
      tick(11); check_eq("t3_id_first", 32'(out_id), 32'd1);
      tick(4);  check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
                check_eq("t3_hold_id", 32'(out_id), 32'd1);
      out_ready = 1'b1;
      tick(1);  check_eq("t3_b2b_valid", 32'(out_valid), 32'd1);
                check_eq("t3_b2b_id", 32'(out_id), 32'd3);
      tick(1);  check_eq("t3_idle", 32'(out_valid), 32'd0);
      release_and_drain("t3_drain");

      // Drop: re-press button 1 twice while its event is stalled
      out_ready = 1'b0;
      button[1] = 1'b1; exp_q.push_back(2'd1);
      tick(11); check_eq("t4_id", 32'(out_id), 32'd1);
      button[1] = 1'b0; tick(12);
      button[1] = 1'b1; exp_q.push_back(2'd1); tick(12);
      check_eq("t4_drop_first", 32'(dropped), 32'd0);
      button[1] = 1'b0; tick(12);
      button[1] = 1'b1; tick(12);
      check_eq("t4_drop_second", 32'(dropped), 32'd1);
      out_ready = 1'b1;
      tick(1);  check_eq("t4_reload_id", 32'(out_id), 32'd1);
                check_eq("t4_reload_valid", 32'(out_valid), 32'd1);
      tick(1);  check_eq("t4_idle", 32'(out_valid), 32'd0);
      release_and_drain("t4_drain");
      check_eq("t4_drop_sticky", 32'(dropped), 32'd1);

      // Arbitration order after a grant to 0 and a re-press of 0
      out_ready = 1'b0;
      button[0] = 1'b1; button[1] = 1'b1;
      exp_q.push_back(2'd0);
      tick(11); check_eq("t5_first", 32'(out_id), 32'd0);
      button[0] = 1'b0; tick(12);
      button[0] = 1'b1; tick(12);
      exp_q.push_back(RR_SECOND); exp_q.push_back(RR_THIRD);
      out_ready = 1'b1;
      tick(1);  check_eq("t5_second", 32'(out_id), 32'(RR_SECOND));
      tick(1);  check_eq("t5_third", 32'(out_id), 32'(RR_THIRD));
      tick(1);  check_eq("t5_idle", 32'(out_valid), 32'd0);
      release_and_drain("t5_drain");

      // Reset mid-handshake and mid-debounce
      out_ready = 1'b0;
      button[2] = 1'b1;
      tick(11); check_eq("t6_presented", 32'(out_valid), 32'd1);
      button[3] = 1'b1;
      tick(7);
      reset = 1'b1; button[2] = 1'b0;
      tick(1);
      reset = 1'b0;
      check_eq("t6_rst_level", 32'(level), 32'd0);
      check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
      check_eq("t6_rst_id", 32'(out_id), 32'd0);
      check_eq("t6_rst_dropped", 32'(dropped), 32'd0);
      tick(9);  check_eq("t6_level_e8", 32'(level), 32'h0);
      tick(1);  check_eq("t6_level_e9", 32'(level), 32'h8);
                check_eq("t6_valid_e9", 32'(out_valid), 32'd0);
      exp_q.push_back(2'd3);
      out_ready = 1'b1;
      tick(1);  check_eq("t6_valid_e10", 32'(out_valid), 32'd1);
                check_eq("t6_id_e10", 32'(out_id), 32'd3);
      tick(1);  check_eq("t6_idle", 32'(out_valid), 32'd0);
      release_and_drain("t6_drain");

      check_eq("extra_events", 32'(extra_cnt), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
